// File: rtl/baccarat_dealer_fsm.sv
// Dealing and decision controller for one baccarat round: card-load strobes, third-card rules, win lights.
// Optional build macro BACC_TALLY_EN adds saturating player/dealer/tie win tallies.
module baccarat_dealer_fsm #(
    parameter int TALLY_W = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               new_round,
    input  logic [3:0]         pscore,
    input  logic [3:0]         dscore,
    input  logic [3:0]         pcard3,
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light
`ifdef BACC_TALLY_EN
    ,
    output logic [TALLY_W-1:0] player_tally,
    output logic [TALLY_W-1:0] dealer_tally,
    output logic [TALLY_W-1:0] tie_tally
`endif
);

    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_P1   = 4'd1,
        ST_D1   = 4'd2,
        ST_P2   = 4'd3,
        ST_D2   = 4'd4,
        ST_CHK  = 4'd5,
        ST_P3   = 4'd6,
        ST_BCHK = 4'd7,
        ST_D3   = 4'd8,
        ST_RES  = 4'd9,
        ST_DONE = 4'd10
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [5:0] load_s;
    logic [5:0] load_r;

    // Banker third-card table; face cards and tens count as zero.
    function automatic logic banker_draws(input logic [3:0] ds, input logic [3:0] c3);
        logic [3:0] v;
        logic       draw;
        v = (c3 >= 4'd10) ? 4'd0 : c3;
        case (ds)
            4'd0, 4'd1, 4'd2: draw = 1'b1;
            4'd3:             draw = (v != 4'd8);
            4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
            default:          draw = 1'b0;
        endcase
        return draw;
    endfunction

    // Next-state logic for the dealing sequence and draw decisions.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_RST:  state_s = ST_P1;
            ST_P1:   state_s = ST_D1;
            ST_D1:   state_s = ST_P2;
            ST_P2:   state_s = ST_D2;
            ST_D2:   state_s = ST_CHK;
            ST_CHK: begin
                // Any score of 8 or more, including out-of-range values, ends the deal as a natural.
                if ((pscore >= 4'd8) || (dscore >= 4'd8)) begin
                    state_s = ST_RES;
                end else if (pscore <= 4'd5) begin
                    state_s = ST_P3;
                end else if (dscore <= 4'd5) begin
                    state_s = ST_D3;
                end else begin
                    state_s = ST_RES;
                end
            end
            ST_P3:   state_s = ST_BCHK;
            ST_BCHK: begin
                if (banker_draws(dscore, pcard3)) begin
                    state_s = ST_D3;
                end else begin
                    state_s = ST_RES;
                end
            end
            ST_D3:   state_s = ST_RES;
            ST_RES:  state_s = ST_DONE;
            ST_DONE: begin
                if (new_round) begin
                    state_s = ST_P1;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_RST;
        endcase
    end

    // Strobe decode of the upcoming state, registered so each strobe is high exactly while in its state.
    always_comb begin
        load_s = 6'b000000;
        case (state_s)
            ST_P1:   load_s = 6'b100000;
            ST_P2:   load_s = 6'b010000;
            ST_P3:   load_s = 6'b001000;
            ST_D1:   load_s = 6'b000100;
            ST_D2:   load_s = 6'b000010;
            ST_D3:   load_s = 6'b000001;
            default: load_s = 6'b000000;
        endcase
    end

    // State and strobe registers.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            state_r <= ST_RST;
            load_r  <= 6'b000000;
        end else begin
            state_r <= state_s;
            load_r  <= load_s;
        end
    end

    assign {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3} = load_r;

    // Win lights: set on leaving RES, held through DONE, cleared when the next round starts.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else if (state_r == ST_RES) begin
            player_win_light <= (pscore >= dscore);
            dealer_win_light <= (dscore >= pscore);
        end else if ((state_r == ST_DONE) && new_round) begin
            player_win_light <= 1'b0;
            dealer_win_light <= 1'b0;
        end else begin
            player_win_light <= player_win_light;
            dealer_win_light <= dealer_win_light;
        end
    end

`ifdef BACC_TALLY_EN
    localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};
    localparam logic [TALLY_W-1:0] TALLY_ONE = TALLY_W'(1);

    // Saturating round-outcome tallies; only resetb clears them.
    always_ff @(posedge slow_clock) begin
        if (!resetb) begin
            player_tally <= {TALLY_W{1'b0}};
            dealer_tally <= {TALLY_W{1'b0}};
            tie_tally    <= {TALLY_W{1'b0}};
        end else if (state_r == ST_RES) begin
            if ((pscore > dscore) && (player_tally != TALLY_MAX)) begin
                player_tally <= player_tally + TALLY_ONE;
            end else if ((dscore > pscore) && (dealer_tally != TALLY_MAX)) begin
                dealer_tally <= dealer_tally + TALLY_ONE;
            end else if ((pscore == dscore) && (tie_tally != TALLY_MAX)) begin
                tie_tally <= tie_tally + TALLY_ONE;
            end else begin
                player_tally <= player_tally;
            end
        end else begin
            player_tally <= player_tally;
            dealer_tally <= dealer_tally;
            tie_tally    <= tie_tally;
        end
    end
`endif

endmodule

// File: tb/tb_baccarat_dealer_fsm.sv
// Directed bench for baccarat_dealer_fsm: models the card registers and scorehand upstream of the controller.
// Build with BACC_TALLY_EN defined to also exercise the win tallies.
module tb_baccarat_dealer_fsm;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic       new_round  = 1'b0;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       pl, dl;
`ifdef BACC_TALLY_EN
    logic [7:0] player_tally, dealer_tally, tie_tally;
`endif

    baccarat_dealer_fsm #(.TALLY_W(8)) dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .new_round        (new_round),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (pl),
        .dealer_win_light (dl)
`ifdef BACC_TALLY_EN
        ,
        .player_tally     (player_tally),
        .dealer_tally     (dealer_tally),
        .tie_tally        (tie_tally)
`endif
    );

    always #5 slow_clock = ~slow_clock;

    // Upstream card registers; deck[] holds p1,p2,p3,d1,d2,d3 for the current round.
    logic [3:0] deck [6];
    logic [3:0] pc1 = 4'd0, pc2 = 4'd0, pc3 = 4'd0;
    logic [3:0] dc1 = 4'd0, dc2 = 4'd0, dc3 = 4'd0;

    always @(posedge slow_clock) begin
        if (load_pcard1) begin pc1 <= deck[0]; pc2 <= 4'd0; pc3 <= 4'd0; end
        if (load_pcard2) pc2 <= deck[1];
        if (load_pcard3) pc3 <= deck[2];
        if (load_dcard1) begin dc1 <= deck[3]; dc2 <= 4'd0; dc3 <= 4'd0; end
        if (load_dcard2) dc2 <= deck[4];
        if (load_dcard3) dc3 <= deck[5];
    end

    function automatic int cv(input logic [3:0] r);
        return (r >= 4'd10) ? 0 : int'(r);
    endfunction

    assign pscore = 4'((cv(pc1) + cv(pc2) + cv(pc3)) % 10);
    assign dscore = 4'((cv(dc1) + cv(dc2) + cv(dc3)) % 10);
    assign pcard3 = pc3;

    wire [5:0] ld = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3};

    int nchecks = 0;
    int nerr    = 0;

    task automatic check(input string tag, input int got, input int exp);
        nchecks++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Plays one round from its first strobe to DONE, then checks the lights hold.
    task automatic play(input string tag,
                        input logic [3:0] p1, input logic [3:0] p2, input logic [3:0] p3,
                        input logic [3:0] d1, input logic [3:0] d2, input logic [3:0] d3,
                        input bit exp_p3, input bit exp_d3, input logic [1:0] exp_lights,
                        input bit hold_nr);
        logic [5:0] exp_seq [12];
        int  n;
        int  cyc;
        bit  started;
        bit  done;
        deck[0] = p1; deck[1] = p2; deck[2] = p3;
        deck[3] = d1; deck[4] = d2; deck[5] = d3;
        exp_seq[0] = 6'b100000;
        exp_seq[1] = 6'b000100;
        exp_seq[2] = 6'b010000;
        exp_seq[3] = 6'b000010;
        exp_seq[4] = 6'b000000;
        n = 5;
        if (exp_p3) begin
            exp_seq[n] = 6'b001000;
            exp_seq[n + 1] = 6'b000000;
            n = n + 2;
        end
        if (exp_d3) begin
            exp_seq[n] = 6'b000001;
            n = n + 1;
        end
        exp_seq[n] = 6'b000000;
        n = n + 1;
        started = 1'b0;
        done    = 1'b0;
        cyc     = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge slow_clock);
            if (!hold_nr) new_round = 1'b0;
            if (!started && load_pcard1) started = 1'b1;
            if (started) begin
                if ({pl, dl} != 2'b00) begin
                    done = 1'b1;
                    new_round = 1'b0;
                    check({tag, " latency"}, cyc, n);
                    check({tag, " lights"}, int'({pl, dl}), int'(exp_lights));
                    check({tag, " done_loads"}, int'(ld), 0);
                end else begin
                    if (cyc < n) check({tag, " seq"}, int'(ld), int'(exp_seq[cyc]));
                    else check({tag, " overrun"}, cyc, n);
                    cyc++;
                end
            end
        end
        if (!done) check({tag, " timeout"}, 0, 1);
        repeat (3) @(negedge slow_clock);
        check({tag, " hold_lights"}, int'({pl, dl}), int'(exp_lights));
        check({tag, " hold_loads"}, int'(ld), 0);
    endtask

    initial begin
        bit found;
        repeat (3) @(negedge slow_clock);
        check("reset_loads", int'(ld), 0);
        check("reset_lights", int'({pl, dl}), 0);
`ifdef BACC_TALLY_EN
        check("reset_tallies", int'({player_tally, dealer_tally, tie_tally}), 0);
`endif
        resetb = 1'b1;
        // P 9 natural vs D 6
        play("t1", 4'd4, 4'd5, 4'd0, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        // P 5 draws 8 -> 3; banker 3 stands on an 8; tie
        new_round = 1'b1;
        play("t2", 4'd2, 4'd3, 4'd8, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0);
        // P 5 draws K -> 5; banker 4 stands on 0; new_round held high mid-round
        new_round = 1'b1;
        play("t3", 4'd1, 4'd4, 4'd13, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 2'b10, 1'b1);
        // P 6 stands; banker 5 draws 3 -> 8
        new_round = 1'b1;
        play("t4", 4'd3, 4'd3, 4'd0, 4'd1, 4'd4, 4'd3, 1'b0, 1'b1, 2'b01, 1'b0);
        // P 4 draws 5 -> 9; banker 5 draws on 5, gets 2 -> 7
        new_round = 1'b1;
        play("t_both", 4'd2, 4'd2, 4'd5, 4'd2, 4'd3, 4'd2, 1'b1, 1'b1, 2'b10, 1'b0);
        // Banker natural 8 against player 2
        new_round = 1'b1;
        play("t_dnat", 4'd1, 4'd1, 4'd0, 4'd4, 4'd4, 4'd0, 1'b0, 1'b0, 2'b01, 1'b0);

        resetb = 1'b0;
        @(negedge slow_clock);
        check("rst_done_lights", int'({pl, dl}), 0);
        resetb = 1'b1;

        // Reset pulsed while in P3
        deck[0] = 4'd2; deck[1] = 4'd3; deck[2] = 4'd8;
        deck[3] = 4'd1; deck[4] = 4'd2; deck[5] = 4'd0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge slow_clock);
            if (load_pcard3) found = 1'b1;
        end
        check("t5 reach_p3", int'(found), 1);
        resetb = 1'b0;
        @(negedge slow_clock);
        check("t5 rst_loads", int'(ld), 0);
        check("t5 rst_lights", int'({pl, dl}), 0);
        resetb = 1'b1;
        play("t5", 4'd3, 4'd3, 4'd0, 4'd1, 4'd4, 4'd3, 1'b0, 1'b1, 2'b01, 1'b0);

`ifdef BACC_TALLY_EN
        resetb = 1'b0;
        @(negedge slow_clock);
        resetb = 1'b1;
        play("t6a", 4'd4, 4'd5, 4'd0, 4'd3, 4'd3, 4'd0, 1'b0, 1'b0, 2'b10, 1'b0);
        new_round = 1'b1;
        play("t6b", 4'd1, 4'd4, 4'd13, 4'd2, 4'd2, 4'd0, 1'b1, 1'b0, 2'b10, 1'b0);
        new_round = 1'b1;
        play("t6c", 4'd2, 4'd3, 4'd8, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, 2'b11, 1'b0);
        check("t6 player_tally", int'(player_tally), 2);
        check("t6 dealer_tally", int'(dealer_tally), 0);
        check("t6 tie_tally", int'(tie_tally), 1);
        resetb = 1'b0;
        @(negedge slow_clock);
        check("t6 rst_tallies", int'({player_tally, dealer_tally, tie_tally}), 0);
        resetb = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
